// File: rtl/mod_arith_pkg.sv
// Shared constants for the digit-serial modular arithmetic datapath:
// operand/digit widths, FSM state encoding and op encoding.
package mod_arith_pkg;

  localparam int unsigned WIDTH      = 256;
  localparam int unsigned DIGIT      = 32;
  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PASS1 = 2'd1;
  localparam logic [1:0] ST_PASS2 = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_serial_if.sv
// Start/done request interface between the arithmetic sequencer (master)
// and the serial modular adder/subtractor (slave).
interface mod_addsub_serial_if;
  import mod_arith_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, m, input busy, done, result);
  modport slave  (input start, op, a, b, m, output busy, done, result);
endinterface

// File: rtl/digit_addsub.sv
// Combinational W-bit add/sub slice: sum = x + (invert_y ? ~y : y) + c_in.
module digit_addsub #(
  parameter int unsigned W = mod_arith_pkg::DIGIT
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_invert_y,
  input  logic         i_c_in,
  output logic [W-1:0] o_sum_c,
  output logic         o_c_out_c
);

  logic [W-1:0] w_y_eff;
  logic [W:0]   w_full;

  assign w_y_eff = i_y ^ {W{i_invert_y}};
  assign w_full  = (W+1)'(i_x) + (W+1)'(w_y_eff) + (W+1)'(i_c_in);
  assign {o_c_out_c, o_sum_c} = w_full;

endmodule

// File: rtl/mod_addsub_serial.sv
// Digit-serial (a +/- b) mod m using one shared DIGIT-bit slice over two passes.
// MOD_ADDSUB_CONST_TIME_EN: always run PASS2 so latency is data-independent.
module mod_addsub_serial
  import mod_arith_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mod_addsub_serial_if.slave   bus
);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_m;
  logic [WIDTH-1:0]       r_t;
  logic [WIDTH-DIGIT-1:0] r_u;
  logic [WIDTH-1:0]       r_result;
  logic                   r_op;
  logic                   r_carry;
  logic                   r_c1;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_pass1;
  logic                   w_last;
  logic [DIGIT-1:0]       w_x;
  logic [DIGIT-1:0]       w_y;
  logic [DIGIT-1:0]       w_sum;
  logic                   w_inv;
  logic                   w_cin;
  logic                   w_cout;
  logic [WIDTH-1:0]       w_t_full;
  logic [WIDTH-1:0]       w_t_rot;
  logic [WIDTH-1:0]       w_u_full;
  logic [WIDTH-1:0]       w_result_nxt;
  logic                   w_skip_pass2;

  assign w_pass1 = (r_state == ST_PASS1);
  assign w_last  = (r_cnt == CNT_W'(NUM_DIGITS - 1));

  // PASS1 consumes a/b, PASS2 consumes t/m; inversion and initial carry
  // are op-dependent (PASS1: op, PASS2: ~op) and coincide.
  assign w_x   = w_pass1 ? r_a[DIGIT-1:0] : r_t[DIGIT-1:0];
  assign w_y   = w_pass1 ? r_b[DIGIT-1:0] : r_m[DIGIT-1:0];
  assign w_inv = w_pass1 ? r_op : ~r_op;
  assign w_cin = (r_cnt == '0) ? w_inv : r_carry;

  digit_addsub #(.W(DIGIT)) u_slice (
    .i_x        (w_x),
    .i_y        (w_y),
    .i_invert_y (w_inv),
    .i_c_in     (w_cin),
    .o_sum_c    (w_sum),
    .o_c_out_c  (w_cout)
  );

  // t is rotated during PASS2 so it is back in place for the final select.
  assign w_t_full = {w_sum, r_t[WIDTH-1:DIGIT]};
  assign w_t_rot  = {r_t[DIGIT-1:0], r_t[WIDTH-1:DIGIT]};
  assign w_u_full = {w_sum, r_u};

`ifdef MOD_ADDSUB_CONST_TIME_EN
  assign w_skip_pass2 = 1'b0;
`else
  assign w_skip_pass2 = (r_op == OP_SUB) && w_cout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_PASS1;
      ST_PASS1: if (w_last) w_state_nxt = w_skip_pass2 ? ST_FIN : ST_PASS2;
      ST_PASS2: if (w_last) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Result as it will be on entry to FIN; from PASS1 only the no-borrow skip gets there.
  always_comb begin
    w_result_nxt = r_result;
    if (w_pass1)
      w_result_nxt = w_t_full;
    else if (r_op == OP_ADD)
      w_result_nxt = (r_c1 | w_cout) ? w_u_full : w_t_rot;
    else
      w_result_nxt = r_c1 ? w_t_rot : w_u_full;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_u      <= '0;
      r_result <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_c1     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_busy <= (w_state_nxt == ST_PASS1) || (w_state_nxt == ST_PASS2);
      r_done <= (w_state_nxt == ST_FIN);
      if (w_state_nxt == ST_FIN) r_result <= w_result_nxt;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_m   <= bus.m;
            r_op  <= bus.op;
            r_cnt <= '0;
          end
        end
        ST_PASS1: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_t     <= w_t_full;
          r_carry <= w_cout;
          r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (w_last) r_c1 <= w_cout;
        end
        ST_PASS2: begin
          r_m     <= r_m >> DIGIT;
          r_t     <= w_t_rot;
          r_u     <= w_u_full[WIDTH-1:DIGIT];
          r_carry <= w_cout;
          r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: doc/mod_addsub_serial.md
Name: mod_addsub_serial

Overview:
- Digit-serial modular adder/subtractor for the 256-bit arithmetic datapath; computes (a + b) mod m or (a - b) mod m.
- Operands must already be reduced: a < m and b < m.
- Trades area for latency: one DIGIT-bit add/sub slice is reused over NUM_DIGITS cycles per pass, with two passes.
- Driven by the higher-level arithmetic sequencer through a start/done handshake.

Parameters:
- WIDTH, 256: operand width in bits.
- DIGIT, 32: bits processed per cycle; WIDTH must be divisible by DIGIT.
- NUM_DIGITS, WIDTH/DIGIT (derived): digits per pass.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- m  input  WIDTH  modulus; latched with start.
- busy  output  1  high from the cycle after start accepted until done.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  reduced result; held until next done.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, result=0; all internal registers cleared. Reset mid-operation aborts the operation, with no done.
- Start acceptance:
  - start is accepted only in IDLE; a_r, b_r, m_r and op_r are latched at that edge.
  - start while busy, or in the DONE cycle, is ignored.
- States and transitions: IDLE -> PASS1 -> PASS2 -> FIN -> IDLE.
- PASS1 (NUM_DIGITS cycles), least-significant digit first:
  - Computes t = a_r + b_r (add) or a_r + ~b_r + 1 (sub).
  - Carry is registered between digits; the initial carry-in equals op_r.
  - Each t digit is shifted into the t register.
  - c1 = final carry-out.
- PASS2 (NUM_DIGITS cycles):
  - Add: u = t + ~m_r + 1 (i.e. t - m); c2 = final carry.
  - Sub: u = t + m_r, initial carry 0.
- FIN (1 cycle), select:
  - Add: result = u if (c1 | c2), else t. Covers both t >= m and sum overflow past WIDTH bits.
  - Sub: result = u if c1 == 0 (borrow, a < b), else t.
  - done=1 and busy=0 in this cycle; next state IDLE.
- Latency:
  - start edge to done = 2*NUM_DIGITS + 1 cycles (17 at defaults).
  - Throughput: one operation per 2*NUM_DIGITS + 2 cycles. Back-to-back start is allowed in the IDLE cycle right after FIN.
- Digit counter: log2(NUM_DIGITS) bits, wraps to 0 at the end of each pass. The pass-end decision uses counter == NUM_DIGITS-1.
- Boundary cases:
  - a == b under sub gives result 0.
  - a + b == m gives result 0.
  - m = 2^WIDTH-1 with maximal operands exercises c1 = 1.

Optional Feature:
- Macro: MOD_ADDSUB_CONST_TIME_EN.
- Defined: PASS2 always executes; latency is fixed at 2*NUM_DIGITS + 1 for both ops and all data, giving a side-channel-safe schedule.
- Undefined: for sub with c1 == 1 (no borrow), the FSM skips PASS2 and goes PASS1 -> FIN, so result = t and latency = NUM_DIGITS + 1. The add path is unchanged.

Decomposition:
- Shared package mod_arith_pkg:
  - Constants WIDTH, DIGIT, NUM_DIGITS.
  - FSM state encoding (IDLE, PASS1, PASS2, FIN).
  - Op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module digit_addsub: combinational DIGIT-bit slice with x, y, invert_y, c_in -> sum, c_out. It is instantiated once and shared by both passes.
- The top holds the FSM, operand shift registers, t/u registers and the result select.

Test Plan (WIDTH=256, DIGIT=32 unless noted):
- Add, m=97, a=50, b=60 -> result=13, done at cycle 17, busy high for cycles 1..16.
- Add, m=97, a=10, b=20 -> result=30. Then sub, a=10, b=20 -> result=87.
- Sub, m=97, a=20, b=10 -> result=10. Latency is 17 with MOD_ADDSUB_CONST_TIME_EN and 9 without.
- Add, m=2^256-1, a=b=2^256-2 -> result=2^256-3 (c1=1 path). Sub with a=b -> result=0.
- Start pulsed again at cycle 5 with different operands -> ignored; first result is unaffected.
- rst asserted at cycle 8 of an operation -> busy, done and result go to 0 immediately with no done pulse. A fresh start then completes normally.
